// File: rtl/cover_toggle_sched.sv
// cover_toggle_sched
// Gathers per-cycle toggle-coverage hits from NUM_GRP cover groups, drops points that
// were already reported since the last reset/clear, and serialises each newly hit point
// into a single cover-index stream toward the coverage report sink.
//
// Output handshake: out_valid is high whenever the FIFO holds a report and out_index
// carries that report; a beat transfers on a rising clock edge where out_valid && out_ready.
// While out_valid && !out_ready, out_valid and out_index hold steady.
module cover_toggle_sched #(
    parameter int                NUM_GRP    = 4,
    parameter int                GRP_W      = 5,
    parameter int                FIFO_DEPTH = 8,
    parameter int                IDX_W      = 32,
    parameter logic [IDX_W-1:0]  COVER_BASE = '0
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NUM_GRP*GRP_W-1:0]               hit,
    input  logic                                   enable,
    input  logic                                   clear,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [IDX_W-1:0]                       out_index,
    output logic [$clog2(NUM_GRP*GRP_W+1)-1:0]     pend_cnt,
    output logic                                   busy,
    output logic                                   all_covered
);

    localparam int NPTS = NUM_GRP * GRP_W;
    localparam int PW   = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam int CW   = $clog2(NPTS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [PW:0]   NPTS_W    = (PW+1)'(NPTS);
    localparam logic [PW-1:0] LAST_PT   = PW'(NPTS - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(FIFO_DEPTH);

    // Architectural state
    logic [NPTS-1:0]  seen_q, seen_d;
    logic [NPTS-1:0]  pend_q, pend_d;
    logic [PW-1:0]    rr_q, rr_d;
    logic [PW-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    // Registered status outputs
    logic [CW-1:0]    pend_cnt_q, pend_cnt_d;
    logic             busy_q, busy_d;
    logic             all_cov_q, all_cov_d;

    // Combinational helpers
    logic [NPTS-1:0]  seen_eff;
    logic [NPTS-1:0]  new_hits;
    logic [NPTS-1:0]  grant_mask;
    logic             grant_found;
    logic [PW-1:0]    grant_idx;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;

    // Capture of new hits against the (possibly just cleared) seen map
    always_comb begin
        seen_eff = clear ? '0 : seen_q;
        new_hits = hit & ~seen_eff & {NPTS{enable}};
        seen_d   = seen_eff | new_hits;
    end

    // Round-robin search: first pending point at or after rr_q, wrapping to 0
    always_comb begin
        logic [PW:0] sum;
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        for (int k = 0; k < NPTS; k++) begin
            sum = {1'b0, rr_q} + (PW+1)'(k);
            if (sum >= NPTS_W) begin
                sum = sum - NPTS_W;
            end
            if (!grant_found && pend_q[sum[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[PW-1:0];
            end
        end
    end

    // FIFO control, grant decision and next-state of pend/rr/pointers
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_W);
        pop        = !fifo_empty && out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept a grant
        push       = grant_found && (!fifo_full || pop);
        grant_mask = push ? (NPTS'(1) << grant_idx) : '0;
        pend_d     = (pend_q & ~grant_mask) | new_hits;
        rr_d       = rr_q;
        if (push) begin
            rr_d = (grant_idx == LAST_PT) ? '0 : grant_idx + PW'(1);
        end
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Status values derived from the post-edge state
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < NPTS; i++) begin
            pend_cnt_d = pend_cnt_d + CW'(pend_d[i]);
        end
        busy_d    = (|pend_d) || (count_d != '0);
        all_cov_d = &seen_d;
    end

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            seen_q     <= '0;
            pend_q     <= '0;
            rr_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pend_cnt_q <= '0;
            busy_q     <= 1'b0;
            all_cov_q  <= 1'b0;
        end else begin
            seen_q     <= seen_d;
            pend_q     <= pend_d;
            rr_q       <= rr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pend_cnt_q <= pend_cnt_d;
            busy_q     <= busy_d;
            all_cov_q  <= all_cov_d;
        end
    end

    // FIFO storage; contents are don't-care while the slot is not occupied
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= grant_idx;
        end
    end

    // Output drive: head of FIFO offset by COVER_BASE, wrapping in IDX_W bits
    always_comb begin
        out_valid   = !fifo_empty;
        out_index   = fifo_empty ? '0 : COVER_BASE + IDX_W'(mem_q[rd_ptr_q]);
        pend_cnt    = pend_cnt_q;
        busy        = busy_q;
        all_covered = all_cov_q;
    end

endmodule
